// File: rtl/memristor_pkg.sv
// Shared definitions for the memristor pulse sequencer.
//   op_e       : command opcode encoding carried on cmd_op
//   state_e    : sequencer FSM states
//   ch_width() : width of the channel-select field for a given channel count
package memristor_pkg;

    typedef enum logic [1:0] {
        OpSet     = 2'b00,
        OpReset   = 2'b01,
        OpRead    = 2'b10,
        OpIllegal = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StPulse  = 2'b01,
        StSettle = 2'b10,
        StDone   = 2'b11
    } state_e;

    // A single channel still needs a 1-bit select field.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter used to time both the pulse and the settle phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   load_val   : cycle count for the next phase
//   en         : decrement by one (saturates at zero)
//   expired    : current cycle is the last cycle of the timed phase
module pulse_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // A loaded value of N gives N cycles before expiry; zero behaves like one.
    assign expired = (count_q <= CNT_W'(1));

endmodule

// File: rtl/memristor_seq_ctrl.sv
// Memristor SET/RESET/READ pulse sequencer.
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_op, cmd_ch      : opcode and target channel
//   cmd_width, cmd_reps : pulse length in cycles and pulse count (0 means 1)
//   abort               : ends an active sequence with err
//   sel, din            : registered per-channel drive
//   busy, done, err     : status; err is meaningful while done is high
module memristor_seq_ctrl
    import memristor_pkg::*;
#(
    parameter int unsigned NCH   = 3,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned GAP   = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [ch_width(NCH)-1:0]      cmd_ch,
    input  logic [CNT_W-1:0]              cmd_width,
    input  logic [3:0]                    cmd_reps,
    input  logic                          abort,
    output logic [NCH-1:0]                sel,
    output logic [NCH-1:0]                din,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned CH_W = ch_width(NCH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [3:0]       reps_q, reps_d;
    logic             err_q, err_d;
    logic             init_q;
    logic [NCH-1:0]   sel_q, sel_d, din_q, din_d;

    logic             accept;
    logic             cmd_bad;
    logic             tmr_load, tmr_en, tmr_expired;
    logic [CNT_W-1:0] tmr_val;

    pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    // init_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = (state_q == StIdle) && init_q;
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_bad   = (op_e'(cmd_op) == OpIllegal) || (32'(cmd_ch) >= NCH);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ch_d     = ch_q;
        width_d  = width_q;
        reps_d   = reps_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = width_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = op_e'(cmd_op);
                    ch_d    = cmd_ch;
                    width_d = (cmd_width == '0) ? CNT_W'(1) : cmd_width;
                    reps_d  = (cmd_reps == '0) ? 4'd1 : cmd_reps;
                    if (cmd_bad) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = StPulse;
                        err_d    = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = width_d;
                    end
                end
            end
            StPulse: begin
                if (abort) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (tmr_expired) begin
                    state_d  = StSettle;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (tmr_expired) begin
                    reps_d = reps_q - 1'b1;
                    if (reps_q <= 4'd1) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StPulse;
                        tmr_load = 1'b1;
                        tmr_val  = width_q;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Drive is computed from the next state so that sel/din are registered yet
    // line up with the PULSE state cycle for cycle.
    always_comb begin
        sel_d = '0;
        din_d = '0;
        if (state_d == StPulse) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_d == CH_W'(i)) begin
                    case (op_d)
                        OpSet:   begin sel_d[i] = 1'b1; din_d[i] = 1'b1; end
                        OpReset: begin sel_d[i] = 1'b1; end
                        OpRead:  begin din_d[i] = 1'b1; end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            op_q    <= OpSet;
            ch_q    <= '0;
            width_q <= CNT_W'(1);
            reps_q  <= 4'd1;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
            sel_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ch_q    <= ch_d;
            width_q <= width_d;
            reps_q  <= reps_d;
            err_q   <= err_d;
            init_q  <= 1'b1;
            sel_q   <= sel_d;
            din_q   <= din_d;
        end
    end

    assign sel  = sel_q;
    assign din  = din_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign err  = done && err_q;

endmodule

// File: doc/memristor_seq_ctrl.md
MEMRISTOR_SEQ_CTRL -- requirements
Module: memristor_seq_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 3: number of memristor channels (SEL/DIGITALIN pairs); legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 16: pulse-width counter width.
REQ-003 SHALL have parameter GAP, default 4: settle cycles after each pulse; legal range 1..2^CNT_W-1.
REQ-004 SHALL have wb_clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have wb_rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have cmd_valid, input, 1: command present.
REQ-007 SHALL have cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have cmd_op, input, 2: 00 SET, 01 RESET, 10 READ, 11 illegal.
REQ-009 SHALL have cmd_ch, input, clog2(NCH) (min 1): target channel.
REQ-010 SHALL have cmd_width, input, CNT_W: pulse length in cycles.
REQ-011 SHALL have cmd_reps, input, 4: number of pulses.
REQ-012 SHALL have abort, input, 1: synchronous abort.
REQ-013 SHALL have sel, output, NCH: per-channel SEL drive.
REQ-014 SHALL have din, output, NCH: per-channel DIGITALIN drive.
REQ-015 SHALL have busy, output, 1; done, output, 1 (one-cycle pulse); err, output, 1 (valid while done is high).

Function
REQ-016 SHALL implement FSM IDLE -> PULSE -> SETTLE -> (PULSE | DONE) -> IDLE.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; busy = state != IDLE.
REQ-018 SHALL latch op, ch, width and reps on acceptance; later input changes have no effect.
REQ-019 SHALL treat width 0 as 1 and reps 0 as 1.
REQ-020 SHALL, for a command accepted at edge T, hold PULSE for exactly W cycles starting at T+1, then SETTLE for exactly GAP cycles.
REQ-021 SHALL drive during PULSE on the latched channel only: SET sel=1 din=1; RESET sel=1 din=0; READ sel=0 din=1.
REQ-022 SHALL drive all other channels, and all channels in IDLE/SETTLE/DONE, to sel=0 din=0.
REQ-023 SHALL decrement the remaining-rep count at the end of each SETTLE; go to PULSE if nonzero, else DONE.
REQ-024 SHALL remain in DONE for one cycle with done=1, err=0, then return to IDLE; earliest next acceptance is in that IDLE cycle.
REQ-025 SHALL accept op 11, produce no pulse, go straight to DONE with err=1 on the next cycle.
REQ-026 SHALL accept cmd_ch >= NCH, produce no pulse, and signal done=1 err=1 as for op 11.
REQ-027 SHALL, when abort is high in PULSE or SETTLE, drive all sel/din low on the next cycle and enter DONE with err=1.
REQ-028 SHALL ignore abort in IDLE and DONE; with abort and cmd_valid both high in IDLE, the command is accepted.

Reset
REQ-029 SHALL, while wb_rst_ni=0, force state IDLE, sel=0, din=0, busy=0, done=0, err=0 and cmd_ready=0, asynchronously.
REQ-030 SHALL drive cmd_ready=1 from the first clock edge after wb_rst_ni deasserts; reset mid-pulse drops drive immediately with no done.

Structure
REQ-031 SHALL place the op encoding and FSM state enum in shared package memristor_pkg.
REQ-032 SHALL use one sub-module, pulse_timer: CNT_W-bit loadable down-counter with expire flag, reused for PULSE and SETTLE.
REQ-033 SHALL register all sel/din outputs (no combinational path from inputs).

Verification
REQ-034 SHALL pass: NCH=3, SET ch1 width=5 reps=1 -> sel[1]=din[1]=1 for cycles T+1..T+5, low T+6..T+9, done at T+10.
REQ-035 SHALL pass: RESET ch2 width=0 reps=3 -> three 1-cycle sel[2]=1 din[2]=0 pulses spaced by 4 low cycles, one done with err=0.
REQ-036 SHALL pass: READ ch0 width=3 -> sel=000, din[0]=1 for 3 cycles.
REQ-037 SHALL pass: op=11 or ch=3 -> no output activity, done=1 err=1 at T+1.
REQ-038 SHALL pass: abort on 2nd pulse cycle -> outputs 0 next cycle, done=1 err=1, cmd_ready=1 the cycle after.
REQ-039 SHALL pass: wb_rst_ni low mid-PULSE -> sel/din 0 without a clock edge, no done, cmd_ready=1 after release.
